// File: rtl/motor_sup_pkg.sv
`default_nettype none
// motor_sup_pkg: state encodings, fault bit positions and a width helper
// shared by the N-axis motor supervisor. Rev 1.0
package motor_sup_pkg;

  typedef logic [1:0] axis_state_t;

  localparam axis_state_t ST_DISABLED = 2'b00;
  localparam axis_state_t ST_RUN      = 2'b01;
  localparam axis_state_t ST_FAULT    = 2'b10;

  localparam int FLT_LIMIT = 0;
  localparam int FLT_STALL = 1;
  localparam int FLT_JUMP  = 2;

  // Ceiling log2; callers clamp a zero result to one bit.
  function automatic int sup_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_axis_supervisor.sv
`default_nettype none
// motor_axis_supervisor: one axis of DISABLED/RUN/FAULT gating with latched
// limit, stall and encoder-jump faults. Rev 1.0
module motor_axis_supervisor
  import motor_sup_pkg::*;
#(
  parameter int POS_W        = 32,
  parameter int CTRL_W       = 16,
  parameter int STALL_THRESH = 24000,
  parameter int STALL_CYCLES = 1000000,
  parameter int MAX_STEP     = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable_i,
  input  logic                     fault_clear_i,
  input  logic signed [POS_W-1:0]  pos_min_i,
  input  logic signed [POS_W-1:0]  pos_max_i,
  input  logic signed [POS_W-1:0]  pos_i,
  input  logic signed [CTRL_W-1:0] ctrl_i,
  input  logic                     dir1_i,
  input  logic                     dir2_i,
  input  logic                     pwm_i,
  output logic                     dir1_o,
  output logic                     dir2_o,
  output logic                     pwm_o,
  output logic [1:0]               state_o,
  output logic [1:0]               state_next_o,
  output logic [2:0]               fault_code_o
);

  localparam int CNT_W = (sup_clog2(STALL_CYCLES) > 0) ? sup_clog2(STALL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CTRL_W-1:0] CTRL_THRESH = CTRL_W'(STALL_THRESH);
  localparam logic [CTRL_W-1:0] CTRL_SAT    = {1'b0, {(CTRL_W-1){1'b1}}};
  localparam logic [POS_W:0]    STEP_LIMIT  = (POS_W+1)'(MAX_STEP);

  axis_state_t              state_q, state_d;
  logic                     armed_q, armed_d;
  logic [2:0]               fault_code_q, fault_code_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic signed [POS_W-1:0]  pos_prev_q;
  logic                     pwm_q, dir1_q, dir2_q;
  logic                     pwm_d, dir1_d, dir2_d;

  logic signed [POS_W:0]    step;
  logic [POS_W:0]           step_abs;
  logic [CTRL_W-1:0]        ctrl_abs;
  logic                     lim_en, ctrl_pos, ctrl_neg;
  logic                     lim_flt, stall_cond, stall_flt, jump_flt;
  logic [2:0]               flt;

  // One extra bit so a wrap across the signed extremes reads as a huge step.
  assign step     = {pos_i[POS_W-1], pos_i} - {pos_prev_q[POS_W-1], pos_prev_q};
  assign step_abs = step[POS_W] ? -step : step;
  assign ctrl_abs = !ctrl_i[CTRL_W-1] ? ctrl_i :
                    (~|ctrl_i[CTRL_W-2:0]) ? CTRL_SAT : -ctrl_i;

  assign lim_en     = !(pos_min_i > pos_max_i);
  assign ctrl_pos   = !ctrl_i[CTRL_W-1] && (ctrl_i != '0);
  assign ctrl_neg   = ctrl_i[CTRL_W-1];
  assign lim_flt    = lim_en && (((pos_i > pos_max_i) && ctrl_pos) ||
                                 ((pos_i < pos_min_i) && ctrl_neg));
  assign stall_cond = (ctrl_abs >= CTRL_THRESH) && (pos_i == pos_prev_q);
  assign stall_flt  = stall_cond && (stall_cnt_q >= CNT_LAST);
  assign jump_flt   = step_abs > STEP_LIMIT;

  always_comb begin
    flt            = 3'b000;
    flt[FLT_LIMIT] = lim_flt;
    flt[FLT_STALL] = stall_flt;
    flt[FLT_JUMP]  = jump_flt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_DISABLED;
      armed_q      <= 1'b0;
      fault_code_q <= 3'b000;
      stall_cnt_q  <= '0;
      pos_prev_q   <= '0;
      pwm_q        <= 1'b0;
      dir1_q       <= 1'b0;
      dir2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      fault_code_q <= fault_code_d;
      stall_cnt_q  <= stall_cnt_d;
      pos_prev_q   <= pos_i;
      pwm_q        <= pwm_d;
      dir1_q       <= dir1_d;
      dir2_q       <= dir2_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_DISABLED: begin
        if (enable_i && armed_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (|flt) begin
          state_d      = ST_FAULT;
          fault_code_d = flt;
        end else if (!enable_i) begin
          state_d = ST_DISABLED;
        end
      end
      ST_FAULT: begin
        if (fault_clear_i) begin
          state_d      = ST_DISABLED;
          fault_code_d = 3'b000;
        end
      end
      default: begin
        state_d      = ST_FAULT;
        fault_code_d = 3'b000;
      end
    endcase

    // A held enable must be released before the axis can run again.
    if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
      armed_d = 1'b0;
    end else if (!enable_i) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    if ((state_q == ST_RUN) && (state_d == ST_RUN) && stall_cond) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_d = '0;
    end
  end

  always_comb begin
    pwm_d  = (state_q == ST_RUN) && pwm_i;
    dir1_d = (state_q == ST_RUN) && dir1_i;
    dir2_d = (state_q == ST_RUN) && dir2_i;
  end

  assign pwm_o        = pwm_q;
  assign dir1_o       = dir1_q;
  assign dir2_o       = dir2_q;
  assign state_o      = state_q;
  assign state_next_o = state_d;
  assign fault_code_o = fault_code_q;

endmodule
`default_nettype wire

// File: rtl/motor_supervisor_nch.sv
`default_nettype none
// motor_supervisor_nch: N-axis safety gate between PID/PWM generators and the
// H-bridges, with fault status readback and a scanned debug LED bank. Rev 1.0
module motor_supervisor_nch
  import motor_sup_pkg::*;
#(
  parameter int N_AXES          = 2,
  parameter int POS_W           = 32,
  parameter int CTRL_W          = 16,
  parameter int STALL_THRESH    = 24000,
  parameter int STALL_CYCLES    = 1000000,
  parameter int MAX_STEP        = 64,
  parameter int LED_SCAN_CYCLES = 50000000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_AXES-1:0]          enable,
  input  logic [N_AXES-1:0]          fault_clear,
  input  logic [N_AXES*POS_W-1:0]    pos_min,
  input  logic [N_AXES*POS_W-1:0]    pos_max,
  input  logic [N_AXES*POS_W-1:0]    actual_pos,
  input  logic [N_AXES*CTRL_W-1:0]   ctrl_in,
  input  logic [N_AXES-1:0]          dir1_in,
  input  logic [N_AXES-1:0]          dir2_in,
  input  logic [N_AXES-1:0]          pwm_in,
  output logic [N_AXES-1:0]          dir1_out,
  output logic [N_AXES-1:0]          dir2_out,
  output logic [N_AXES-1:0]          pwm_out,
  output logic [N_AXES*2-1:0]        axis_state,
  output logic [N_AXES*3-1:0]        fault_code,
  output logic                       any_fault,
  output logic [3:0]                 led
);

  localparam int SCAN_W = (sup_clog2(LED_SCAN_CYCLES) > 0) ? sup_clog2(LED_SCAN_CYCLES) : 1;
  localparam int IDX_W  = (sup_clog2(N_AXES) > 0) ? sup_clog2(N_AXES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(LED_SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_AXES - 1);

  axis_state_t         state_w      [N_AXES];
  axis_state_t         state_next_w [N_AXES];
  logic [N_AXES-1:0]   fault_next;

  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
  logic                heartbeat_q, heartbeat_d;
  logic                any_fault_q;
  logic                scan_step;

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    motor_axis_supervisor #(
      .POS_W        (POS_W),
      .CTRL_W       (CTRL_W),
      .STALL_THRESH (STALL_THRESH),
      .STALL_CYCLES (STALL_CYCLES),
      .MAX_STEP     (MAX_STEP)
    ) u_axis (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable_i      (enable[i]),
      .fault_clear_i (fault_clear[i]),
      .pos_min_i     (pos_min[i*POS_W +: POS_W]),
      .pos_max_i     (pos_max[i*POS_W +: POS_W]),
      .pos_i         (actual_pos[i*POS_W +: POS_W]),
      .ctrl_i        (ctrl_in[i*CTRL_W +: CTRL_W]),
      .dir1_i        (dir1_in[i]),
      .dir2_i        (dir2_in[i]),
      .pwm_i         (pwm_in[i]),
      .dir1_o        (dir1_out[i]),
      .dir2_o        (dir2_out[i]),
      .pwm_o         (pwm_out[i]),
      .state_o       (state_w[i]),
      .state_next_o  (state_next_w[i]),
      .fault_code_o  (fault_code[i*3 +: 3])
    );

    assign axis_state[i*2 +: 2] = state_w[i];
    assign fault_next[i]        = (state_next_w[i] == ST_FAULT);
  end

  always_comb begin
    scan_step   = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_step ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d  = scan_idx_q;
    heartbeat_d = heartbeat_q ^ scan_step;
    if (scan_step) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // any_fault follows the next-state so it lands on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      heartbeat_q <= 1'b0;
      any_fault_q <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      heartbeat_q <= heartbeat_d;
      any_fault_q <= |fault_next;
    end
  end

  assign any_fault = any_fault_q;
  assign led = {heartbeat_q,
                pwm_out[scan_idx_q],
                state_w[scan_idx_q] == ST_FAULT,
                state_w[scan_idx_q] == ST_RUN};

endmodule
`default_nettype wire
